seq_match_ctrl: RTL and testbench

Streaming controller for the serial pattern recognizer datapath. Accepts bytes over a valid/ready handshake, serializes each byte MSB-first at one bit per cycle into a programmable PAT_W-bit pattern matcher, counts matches and raises a sticky interrupt at a programmable threshold. It sits between the byte-oriented host side and the bit-serial recognizer, and sequences and configures the recognizer.

---
 rtl/seq_match_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seq_match_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: byte-in / bit-serial pattern match controller.
// A byte taken over valid/ready is shifted MSB-first, one bit per cycle,
// into a PAT_W-bit history that is compared against a programmable pattern.
// Matches are counted with saturation. A sticky irq is raised when the count
// reaches a programmable nonzero threshold.
// Optional feature macro: SEQ_MATCH_OVERLAP_EN. When it is defined, history is
// kept after a match, so overlapping occurrences are counted. When it is
// undefined, history is cleared on every match.
module seq_match_ctrl #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b0101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             irq_clr,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

  localparam int               HL_W    = $clog2(PAT_W + 1);
  localparam logic [HL_W-1:0]  HL_FULL = HL_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [HL_W-1:0]  hlen_q, hlen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             irq_q, irq_d;
  logic             busy_q, busy_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             bit_s;
  logic [PAT_W-1:0] hist_upd_s;
  logic [HL_W-1:0]  hlen_upd_s;
  logic             hit_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             irq_set_s;
  logic             irq_base_s;

  // Handshake: idle accepts unless config has the cycle; shift accepts on its last bit.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready_s = ~cfg_we;
      ST_SHIFT: in_ready_s = (bit_idx_q == 3'd0);
      default:  in_ready_s = 1'b0;
    endcase
    accept_s = in_valid & in_ready_s;
  end

  // Datapath: the bit consumed this cycle, updated history and the match/irq decision.
  always_comb begin
    bit_s      = shreg_q[7];
    hist_upd_s = {hist_q[PAT_W-2:0], bit_s};
    if (hlen_q == HL_FULL) begin
      hlen_upd_s = HL_FULL;
    end else begin
      hlen_upd_s = hlen_q + HL_W'(1);
    end
    hit_s = (state_q == ST_SHIFT) && (hlen_upd_s == HL_FULL) && (hist_upd_s == pattern_q);
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = cnt_q + CNT_W'(1);
    end
    irq_set_s  = hit_s && (thresh_q != {CNT_W{1'b0}}) && (cnt_inc_s == thresh_q);
    irq_base_s = irq_clr ? 1'b0 : irq_q;
  end

  // Next-state logic for the IDLE/SHIFT controller and all registered outputs.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    pattern_d = pattern_q;
    thresh_d  = thresh_q;
    hist_d    = hist_q;
    hlen_d    = hlen_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    irq_d     = irq_base_s;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          thresh_d  = cfg_thresh;
          hist_d    = {PAT_W{1'b0}};
          hlen_d    = {HL_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          irq_d     = 1'b0;
        end else if (accept_s) begin
          shreg_d   = in_data;
          bit_idx_d = 3'd7;
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[6:0], 1'b0};
        if (hit_s) begin
          match_d = 1'b1;
          cnt_d   = cnt_inc_s;
`ifdef SEQ_MATCH_OVERLAP_EN
          hist_d  = hist_upd_s;
          hlen_d  = hlen_upd_s;
`else
          hist_d  = {PAT_W{1'b0}};
          hlen_d  = {HL_W{1'b0}};
`endif
          if (irq_set_s) begin
            irq_d = 1'b1;
          end else begin
            irq_d = irq_base_s;
          end
        end else begin
          match_d = 1'b0;
          hist_d  = hist_upd_s;
          hlen_d  = hlen_upd_s;
        end
        if (bit_idx_q == 3'd0) begin
          if (accept_s) begin
            shreg_d   = in_data;
            bit_idx_d = 3'd7;
            state_d   = ST_SHIFT;
          end else begin
            bit_idx_d = 3'd0;
            state_d   = ST_IDLE;
          end
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      pattern_q <= PAT_RST;
      thresh_q  <= {CNT_W{1'b0}};
      hist_q    <= {PAT_W{1'b0}};
      hlen_q    <= {HL_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      pattern_q <= pattern_d;
      thresh_q  <= thresh_d;
      hist_q    <= hist_d;
      hlen_q    <= hlen_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      irq_q     <= irq_d;
      busy_q    <= busy_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = busy_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: table of single-byte cases plus
// hand-written multi-cycle sequences, with a per-bit scoreboard.
module tb_seq_match_ctrl;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
`ifdef SEQ_MATCH_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_thresh;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             irq_clr;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;

  seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_RST(4'b0101)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_thresh(cfg_thresh), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .irq_clr(irq_clr), .busy(busy), .match(match),
    .match_cnt(match_cnt), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_err = 0;

  typedef struct { bit m; int cnt; bit irq; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] pat;
    logic [7:0] thr;
    logic [7:0] data;
    int         exp_cnt;
    bit         exp_irq;
  } vec_t;
  vec_t tbl[6];

  // Reference model state
  int m_hist, m_hlen, m_cnt, m_thresh, m_pat;
  bit m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    m_hist = 0; m_hlen = 0; m_cnt = 0; m_irq = 1'b0;
    m_pat = 5; m_thresh = 0;
    sb.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    exp_t e;
    for (int j = 7; j >= 0; j--) begin
      m_hist = ((m_hist << 1) | int'(b[j])) & ((1 << PAT_W) - 1);
      if (m_hlen < PAT_W) m_hlen++;
      e.m = (m_hlen == PAT_W) && (m_hist == m_pat);
      if (e.m) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_thresh != 0 && m_cnt == m_thresh) m_irq = 1'b1;
        if (!OVL) begin m_hist = 0; m_hlen = 0; end
      end
      e.cnt = m_cnt;
      e.irq = m_irq;
      sb.push_back(e);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_cfg(input logic [3:0] p, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_thresh = t;
    step();
    cfg_we = 1'b0;
    m_pat = int'(p); m_thresh = int'(t);
    m_hist = 0; m_hlen = 0; m_cnt = 0; m_irq = 1'b0;
  endtask

  // Offer bytes back to back; every consumed bit is scored against the model.
  task automatic run_stream(input logic [7:0] bytes[$], input bit hold_cfg);
    int   n;
    bit   last;
    exp_t e;
    n = bytes.size();
    in_valid = 1'b1; in_data = bytes[0];
    #1;
    chk("ready_idle", 32'(in_ready), 32'd1);
    step();
    model_byte(bytes[0]);
    in_valid = 1'b0;
    if (hold_cfg) begin
      cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_thresh = 8'd1;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        last = (i == n - 1);
        if (k == 7 && !last) begin
          in_valid = 1'b1; in_data = bytes[i + 1];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        chk("ready_shift", 32'(in_ready), 32'(k == 7));
        step();
        if (k == 7 && last) cfg_we = 1'b0;
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_empty: got no expected entry, required one at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("match", 32'(match), 32'(e.m));
          chk("match_cnt", 32'(match_cnt), 32'(e.cnt));
          chk("irq", 32'(irq), 32'(e.irq));
        end
        chk("busy", 32'(busy), 32'(!(k == 7 && last)));
        if (k == 7 && !last) model_byte(bytes[i + 1]);
      end
    end
    in_valid = 1'b0;
  endtask

  logic [7:0] q[$];

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_pattern = 4'd0; cfg_thresh = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; irq_clr = 1'b0;

    tbl[0] = '{4'b0101, 8'd0, 8'h55, OVL ? 3 : 2, 1'b0};
    tbl[1] = '{4'b0101, 8'd2, 8'h55, OVL ? 3 : 2, 1'b1};
    tbl[2] = '{4'b1111, 8'd0, 8'hFF, OVL ? 5 : 2, 1'b0};
    tbl[3] = '{4'b0000, 8'd1, 8'h0F, 1,           1'b1};
    tbl[4] = '{4'b1010, 8'd3, 8'hAA, OVL ? 3 : 2, OVL};
    tbl[5] = '{4'b0110, 8'd0, 8'h36, OVL ? 2 : 1, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Table-driven single-byte cases
    for (int i = 0; i < 6; i++) begin
      do_reset();
      do_cfg(tbl[i].pat, tbl[i].thr);
      q.delete(); q.push_back(tbl[i].data);
      run_stream(q, 1'b0);
      chk("tbl_cnt", 32'(match_cnt), 32'(tbl[i].exp_cnt));
      chk("tbl_irq", 32'(irq), 32'(tbl[i].exp_irq));
    end

    // irq is sticky until cleared; the count is unaffected by the clear
    do_reset();
    do_cfg(4'b0101, 8'd2);
    q.delete(); q.push_back(8'h55);
    run_stream(q, 1'b0);
    step();
    chk("irq_sticky", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_clr", 32'(irq), 32'd0);
    chk("irq_clr_cnt", 32'(match_cnt), OVL ? 32'd3 : 32'd2);

    // Back-to-back bytes, pattern spans the byte boundary
    do_reset();
    q.delete(); q.push_back(8'h01); q.push_back(8'h40);
    run_stream(q, 1'b0);
    chk("b2b_cnt", 32'(match_cnt), 32'd1);

    // Config and valid in the same idle cycle: config wins
    do_reset();
    cfg_we = 1'b1; cfg_pattern = 4'b0011; cfg_thresh = 8'd0;
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("cfg_ready", 32'(in_ready), 32'd0);
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("cfg_busy", 32'(busy), 32'd0);
    chk("cfg_cnt", 32'(match_cnt), 32'd0);
    m_pat = 3; m_thresh = 0;
    q.delete(); q.push_back(8'h33);
    run_stream(q, 1'b0);
    chk("cfg_newpat_cnt", 32'(match_cnt), 32'd2);

    // Saturation with thresh 0; cfg_we held during SHIFT is ignored
    do_reset();
    do_cfg(4'b0101, 8'd0);
    q.delete();
    for (int i = 0; i < (OVL ? 80 : 150); i++) q.push_back(8'h55);
    run_stream(q, 1'b1);
    chk("sat_cnt", 32'(match_cnt), 32'd255);
    chk("sat_irq", 32'(irq), 32'd0);

    // Reset in the middle of a byte
    do_reset();
    do_cfg(4'b1001, 8'd1);
    in_valid = 1'b1; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
    chk("mid_rst_match", 32'(match), 32'd0);
    model_clear();
    q.delete(); q.push_back(8'h55);
    run_stream(q, 1'b0);
    chk("mid_rst_55_cnt", 32'(match_cnt), OVL ? 32'd3 : 32'd2);
    chk("mid_rst_sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
